// File: rtl/tqv_bus_host.sv
// Bus initiator for the TinyQV peripheral interface: one command in, one strobe sequence on the
// peripheral bus, one response out. All bus and response outputs are registered.
module tqv_bus_host #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // rsp_valid and its payload stay put until that edge, cmd_ready never depends on cmd_valid.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} state_t;

  localparam logic [1:0] SZ_IDLE  = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_d;
  logic [5:0]  r_addr, w_addr_d;
  logic [31:0] r_data_in, w_data_in_d;
  logic [1:0]  r_wr_n, w_wr_n_d;
  logic [1:0]  r_rd_n, w_rd_n_d;
  logic        r_rsp_valid, w_rsp_valid_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_err, w_err_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        w_cmd_fire;

  function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] v);
    case (sz)
      2'b00:   size_mask = {24'h0, v[7:0]};
      2'b01:   size_mask = {16'h0, v[15:0]};
      default: size_mask = v;
    endcase
  endfunction

  assign cmd_ready    = (r_state == ST_IDLE) & rst_n;
  assign w_cmd_fire   = cmd_valid & cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign address      = r_addr;
  assign data_in      = r_data_in;
  assign data_write_n = r_wr_n;
  assign data_read_n  = r_rd_n;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_data_in_d   = r_data_in;
    w_wr_n_d      = r_wr_n;
    w_rd_n_d      = r_rd_n;
    w_rsp_valid_d = r_rsp_valid;
    w_rdata_d     = r_rdata;
    w_err_d       = r_err;
    w_cnt_d       = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_addr_d = cmd_addr;
          if (cmd_size == SZ_IDLE) begin
            // Illegal size never touches the bus.
            w_state_d     = ST_RESP;
            w_rsp_valid_d = 1'b1;
            w_err_d       = 1'b1;
            w_rdata_d     = '0;
          end else if (cmd_write) begin
            w_state_d   = ST_WRITE;
            w_data_in_d = size_mask(cmd_size, cmd_wdata);
            w_wr_n_d    = cmd_size;
          end else begin
            w_state_d = ST_READ;
            w_rd_n_d  = cmd_size;
            w_cnt_d   = '0;
          end
        end
      end
      ST_WRITE: begin
        w_state_d     = ST_RESP;
        w_wr_n_d      = SZ_IDLE;
        w_rsp_valid_d = 1'b1;
        w_err_d       = 1'b0;
        w_rdata_d     = '0;
      end
      ST_READ: begin
        w_cnt_d = r_cnt + 8'd1;
        // r_rd_n still carries the size code of the read in progress.
        if (data_ready) begin
          w_state_d     = ST_RESP;
          w_rd_n_d      = SZ_IDLE;
          w_rsp_valid_d = 1'b1;
          w_err_d       = 1'b0;
          w_rdata_d     = size_mask(r_rd_n, data_out);
        end else if (r_cnt == CNT_LAST) begin
          w_state_d     = ST_RESP;
          w_rd_n_d      = SZ_IDLE;
          w_rsp_valid_d = 1'b1;
          w_err_d       = 1'b1;
          w_rdata_d     = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_d     = ST_IDLE;
          w_rsp_valid_d = 1'b0;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data_in   <= '0;
      r_wr_n      <= SZ_IDLE;
      r_rd_n      <= SZ_IDLE;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_data_in   <= w_data_in_d;
      r_wr_n      <= w_wr_n_d;
      r_rd_n      <= w_rd_n_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rdata     <= w_rdata_d;
      r_err       <= w_err_d;
      r_cnt       <= w_cnt_d;
    end
  end

endmodule
